// File: rtl/bullet_scheduler_if.sv
// Bundle between keycode decode / bullet slot array and the bullet scheduler.
// Pulse semantics: fire_req is a level request. Every other strobe is a
// single-cycle pulse with no backpressure: slot_done, launch and grant. A slot
// acts on launch[i] in the cycle it is high, and slot_done[i] reports one
// death per pulse. dbg_state exposes both player FSMs as {p2_state, p1_state}.
interface bullet_scheduler_if #(parameter int NUM_SLOTS = 4);
  logic [1:0]             fire_req;
  logic [1:0]             dir_p1;
  logic [1:0]             dir_p2;
  logic [NUM_SLOTS-1:0]   slot_done;
  logic [NUM_SLOTS-1:0]   launch;
  logic [2*NUM_SLOTS-1:0] launch_dir;
  logic [NUM_SLOTS-1:0]   slot_busy;
  logic [NUM_SLOTS-1:0]   slot_owner;
  logic [1:0]             grant;
  logic [3:0]             active_p1;
  logic [3:0]             active_p2;
  logic [3:0]             dbg_state;

  modport master (
    output fire_req, dir_p1, dir_p2, slot_done,
    input  launch, launch_dir, slot_busy, slot_owner, grant,
           active_p1, active_p2, dbg_state
  );

  modport slave (
    input  fire_req, dir_p1, dir_p2, slot_done,
    output launch, launch_dir, slot_busy, slot_owner, grant,
           active_p1, active_p2, dbg_state
  );
endinterface

// File: rtl/bullet_scheduler.sv
// Shares a pool of bullet slots between two players. It edge-detects the
// fire requests, enforces a per-player live-bullet cap and a refire
// cooldown, arbitrates round-robin and allocates the lowest free slot.
module bullet_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int COOLDOWN       = 8
) (
  input logic               frame_clk,
  input logic               Reset_n,
  bullet_scheduler_if.slave bus
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;

  logic [1:0]             state_q [2];
  logic [7:0]             cd_q    [2];
  logic [3:0]             active_q[2];
  logic [1:0]             fire_prev_q;
  logic                   rr_q;
  logic [NUM_SLOTS-1:0]   launch_q;
  logic [1:0]             grant_q;
  logic [NUM_SLOTS-1:0]   busy_q;
  logic [NUM_SLOTS-1:0]   owner_q;
  logic [2*NUM_SLOTS-1:0] dir_q;

  logic [1:0]           rise;
  logic [1:0]           elig;
  logic [1:0]           win;
  logic                 gnt_any;
  logic                 any_free;
  logic [NUM_SLOTS-1:0] alloc_oh;
  logic [NUM_SLOTS-1:0] done_eff;
  logic [3:0]           dec[2];
  logic [3:0]           active_nxt[2];

  assign rise     = bus.fire_req & ~fire_prev_q;
  // A done pulse on an idle slot carries no information and is dropped.
  assign done_eff = bus.slot_done & busy_q;

  // Lowest-index free slot, judged on the pre-edge busy vector so a slot
  // freed this cycle is never handed out in the same cycle.
  always_comb begin
    alloc_oh = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!any_free && !busy_q[i]) begin
        any_free    = 1'b1;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  // Eligibility and round-robin pick: rr_q = 0 favours P1, rr_q = 1 favours P2.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      elig[p] = (state_q[p] == ST_ARMED) && bus.fire_req[p] &&
                (active_q[p] < 4'(MAX_PER_PLAYER)) && any_free;
    end
    if (elig == 2'b11) win = rr_q ? 2'b10 : 2'b01;
    else               win = elig;
    gnt_any = |win;
  end

  // Next live-bullet counts: +1 on a launch, -1 per retiring slot owned.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      dec[p] = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (done_eff[i] && (owner_q[i] == p[0])) dec[p] = dec[p] + 4'd1;
      end
      active_nxt[p] = active_q[p] + {3'b000, win[p]} - dec[p];
    end
  end

  // Slot pool, counters, arbitration pointer and both player FSMs.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      fire_prev_q <= '0;
      rr_q        <= 1'b0;
      launch_q    <= '0;
      grant_q     <= '0;
      busy_q      <= '0;
      owner_q     <= '0;
      dir_q       <= '0;
      for (int p = 0; p < 2; p++) begin
        state_q[p]  <= ST_READY;
        cd_q[p]     <= '0;
        active_q[p] <= '0;
      end
    end else begin
      fire_prev_q <= bus.fire_req;
      launch_q    <= gnt_any ? alloc_oh : '0;
      grant_q     <= win;
      busy_q      <= (busy_q & ~done_eff) | (gnt_any ? alloc_oh : '0);
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (gnt_any && alloc_oh[i]) begin
          owner_q[i]      <= win[1];
          dir_q[2*i +: 2] <= win[1] ? bus.dir_p2 : bus.dir_p1;
        end
      end
      // Contested grant: the pointer moves to the loser.
      if (elig == 2'b11) rr_q <= ~rr_q;
      for (int p = 0; p < 2; p++) begin
        active_q[p] <= active_nxt[p];
        case (state_q[p])
          ST_READY: if (rise[p]) state_q[p] <= ST_ARMED;
          ST_ARMED: begin
            if (!bus.fire_req[p]) begin
              state_q[p] <= ST_READY;
            end else if (win[p]) begin
              state_q[p] <= ST_COOL;
              cd_q[p]    <= 8'(COOLDOWN);
            end
          end
          ST_COOL: begin
            if (cd_q[p] <= 8'd1) begin
              state_q[p] <= ST_READY;
              cd_q[p]    <= '0;
            end else begin
              cd_q[p] <= cd_q[p] - 8'd1;
            end
          end
          default: state_q[p] <= ST_READY;
        endcase
      end
    end
  end

  assign bus.launch     = launch_q;
  assign bus.grant      = grant_q;
  assign bus.slot_busy  = busy_q;
  assign bus.slot_owner = owner_q;
  assign bus.launch_dir = dir_q;
  assign bus.active_p1  = active_q[0];
  assign bus.active_p2  = active_q[1];
  assign bus.dbg_state  = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: a negedge scoreboard compares every
// launch against the queue of expected launches.
module tb_bullet_scheduler;
  localparam int NS = 4;
  localparam int RW = NS + 5;
  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;

  logic frame_clk;
  logic Reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  bullet_scheduler_if #(.NUM_SLOTS(NS)) bus();

  bullet_scheduler #(.NUM_SLOTS(NS), .MAX_PER_PLAYER(2), .COOLDOWN(8)) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  // Clock and reset
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic done_pulse(input logic [NS-1:0] m);
    bus.slot_done = m;
    tick(1);
    bus.slot_done = '0;
  endtask

  // Expected launch record: {grant, launch one-hot, slot dir, slot owner}
  function automatic logic [RW-1:0] mk(input logic [1:0] g, input int slot,
                                       input logic [1:0] d, input logic o);
    logic [NS-1:0] oh;
    oh       = '0;
    oh[slot] = 1'b1;
    return {g, oh, d, o};
  endfunction

  // Scoreboard: every launch or grant must match the head of exp_q
  always @(negedge frame_clk) begin
    int idx;
    logic [RW-1:0] obs;
    if (bus.launch != '0 || bus.grant != '0) begin
      idx = 0;
      for (int i = 0; i < NS; i++) if (bus.launch[i]) idx = i;
      obs = {bus.grant, bus.launch, bus.launch_dir[2*idx +: 2], bus.slot_owner[idx]};
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed %0h expected no launch", obs);
        end
      end else begin
        chk("sb_launch", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset with fire held high
    Reset_n = 1'b0; bus.fire_req = 2'b11; bus.dir_p1 = 2'b00; bus.dir_p2 = 2'b00;
    bus.slot_done = '0;
    tick(2);
    chk("rst_launch", 32'(bus.launch), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.slot_busy), 0);
    chk("rst_owner", 32'(bus.slot_owner), 0);
    chk("rst_dir", 32'(bus.launch_dir), 0);
    chk("rst_active_p1", 32'(bus.active_p1), 0);
    chk("rst_active_p2", 32'(bus.active_p2), 0);
    chk("rst_state", 32'(bus.dbg_state), 0);
    Reset_n = 1'b1; bus.fire_req = 2'b00;
    tick(5);
    chk("idle_busy", 32'(bus.slot_busy), 0);

    // Single P1 fire, latency and no refire while held
    bus.dir_p1 = 2'b11; bus.fire_req = 2'b01;
    exp_q.push_back(mk(2'b01, 0, 2'b11, 1'b0));
    tick(1);
    chk("p1_first_edge_launch", 32'(bus.launch), 0);
    chk("p1_armed", 32'(bus.dbg_state[1:0]), 32'(ST_ARMED));
    tick(1);
    chk("p1_launch", 32'(bus.launch), 32'h1);
    chk("p1_grant", 32'(bus.grant), 32'h1);
    chk("p1_dir", 32'(bus.launch_dir[1:0]), 32'h3);
    chk("p1_active", 32'(bus.active_p1), 1);
    tick(20);
    chk("p1_hold_active", 32'(bus.active_p1), 1);
    chk("p1_hold_busy", 32'(bus.slot_busy), 32'h1);
    bus.fire_req = 2'b00;
    done_pulse(4'b0001);
    chk("p1_release_busy", 32'(bus.slot_busy), 0);
    chk("p1_release_active", 32'(bus.active_p1), 0);

    // Simultaneous rises, three rounds: first winner P1, P2, P1
    bus.dir_p1 = 2'b01; bus.dir_p2 = 2'b10;
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin
        exp_q.push_back(mk(2'b10, 0, 2'b10, 1'b1));
        exp_q.push_back(mk(2'b01, 1, 2'b01, 1'b0));
      end else begin
        exp_q.push_back(mk(2'b01, 0, 2'b01, 1'b0));
        exp_q.push_back(mk(2'b10, 1, 2'b10, 1'b1));
      end
      bus.fire_req = 2'b11;
      tick(2);
      chk("rr_first_grant", 32'(bus.grant), (r == 1) ? 32'h2 : 32'h1);
      tick(1);
      chk("rr_second_grant", 32'(bus.grant), (r == 1) ? 32'h1 : 32'h2);
      chk("rr_busy", 32'(bus.slot_busy), 32'h3);
      chk("rr_active_p1", 32'(bus.active_p1), 1);
      chk("rr_active_p2", 32'(bus.active_p2), 1);
      bus.fire_req = 2'b00;
      done_pulse(4'b0011);
      tick(10);
    end

    // Per-player cap: third P1 request waits for a slot_done
    bus.dir_p1 = 2'b11;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(2'b01, k, 2'b11, 1'b0));
      bus.fire_req = 2'b01;
      tick(2);
      chk("cap_launch", 32'(bus.launch), 32'(1 << k));
      bus.fire_req = 2'b00;
      tick(10);
    end
    bus.fire_req = 2'b01;
    tick(2);
    chk("cap_blocked_launch", 32'(bus.launch), 0);
    chk("cap_blocked_active", 32'(bus.active_p1), 2);
    tick(5);
    chk("cap_blocked_state", 32'(bus.dbg_state[1:0]), 32'(ST_ARMED));
    exp_q.push_back(mk(2'b01, 0, 2'b11, 1'b0));
    done_pulse(4'b0001);
    chk("cap_freed_no_launch", 32'(bus.launch), 0);
    chk("cap_freed_busy", 32'(bus.slot_busy), 32'h2);
    chk("cap_freed_active", 32'(bus.active_p1), 1);
    tick(1);
    chk("cap_relaunch", 32'(bus.launch), 32'h1);
    chk("cap_relaunch_active", 32'(bus.active_p1), 2);
    bus.fire_req = 2'b00;
    done_pulse(4'b0011);
    tick(10);

    // Fill the pool, then free slots 2 and 3 while P2 is armed
    bus.dir_p1 = 2'b01; bus.dir_p2 = 2'b10;
    exp_q.push_back(mk(2'b10, 0, 2'b10, 1'b1));
    exp_q.push_back(mk(2'b01, 1, 2'b01, 1'b0));
    bus.fire_req = 2'b11;
    tick(3);
    chk("fill_busy_a", 32'(bus.slot_busy), 32'h3);
    bus.fire_req = 2'b00;
    tick(10);
    exp_q.push_back(mk(2'b01, 2, 2'b01, 1'b0));
    exp_q.push_back(mk(2'b10, 3, 2'b10, 1'b1));
    bus.fire_req = 2'b11;
    tick(3);
    chk("fill_busy_b", 32'(bus.slot_busy), 32'hF);
    chk("fill_active_p1", 32'(bus.active_p1), 2);
    chk("fill_active_p2", 32'(bus.active_p2), 2);
    bus.fire_req = 2'b00;
    tick(10);
    bus.fire_req = 2'b10;
    tick(3);
    chk("full_p2_armed", 32'(bus.dbg_state[3:2]), 32'(ST_ARMED));
    chk("full_no_launch", 32'(bus.launch), 0);
    exp_q.push_back(mk(2'b10, 2, 2'b10, 1'b1));
    done_pulse(4'b1100);
    chk("dual_done_no_reuse", 32'(bus.launch), 0);
    chk("dual_done_busy", 32'(bus.slot_busy), 32'h3);
    chk("dual_done_active_p1", 32'(bus.active_p1), 1);
    chk("dual_done_active_p2", 32'(bus.active_p2), 1);
    // Same-cycle launch and retire for P2: net count unchanged
    bus.slot_done = 4'b0001;
    tick(1);
    bus.slot_done = '0;
    chk("realloc_launch", 32'(bus.launch), 32'h4);
    chk("realloc_busy", 32'(bus.slot_busy), 32'h6);
    chk("net_zero_active_p2", 32'(bus.active_p2), 1);
    chk("net_zero_active_p1", 32'(bus.active_p1), 1);
    bus.fire_req = 2'b00;
    done_pulse(4'b0110);
    chk("drain_active_p1", 32'(bus.active_p1), 0);
    chk("drain_active_p2", 32'(bus.active_p2), 0);
    tick(10);

    // Cooldown: rise 3 cycles after a grant is dropped, rise at 10 is taken
    bus.dir_p2 = 2'b00;
    exp_q.push_back(mk(2'b10, 0, 2'b00, 1'b1));
    bus.fire_req = 2'b10;
    tick(2);
    chk("cool_first_launch", 32'(bus.launch), 32'h1);
    bus.fire_req = 2'b00;
    tick(2);
    bus.fire_req = 2'b10;
    tick(2);
    chk("cool_rise_ignored", 32'(bus.launch), 0);
    chk("cool_state", 32'(bus.dbg_state[3:2]), 32'(ST_COOL));
    bus.fire_req = 2'b00;
    tick(5);
    bus.dir_p2 = 2'b01;
    exp_q.push_back(mk(2'b10, 1, 2'b01, 1'b1));
    bus.fire_req = 2'b10;
    tick(1);
    chk("cool_late_armed_launch", 32'(bus.launch), 0);
    tick(1);
    chk("cool_late_launch", 32'(bus.launch), 32'h2);
    chk("cool_late_active", 32'(bus.active_p2), 2);
    chk("dir_held_slot0", 32'(bus.launch_dir[1:0]), 0);

    // Reset during P2 cooldown frees everything
    bus.fire_req = 2'b00;
    Reset_n = 1'b0;
    tick(1);
    chk("midrst_busy", 32'(bus.slot_busy), 0);
    chk("midrst_active_p2", 32'(bus.active_p2), 0);
    chk("midrst_state", 32'(bus.dbg_state), 0);
    chk("midrst_launch", 32'(bus.launch), 0);
    Reset_n = 1'b1;
    exp_q.push_back(mk(2'b10, 0, 2'b01, 1'b1));
    bus.fire_req = 2'b10;
    tick(2);
    chk("post_rst_launch", 32'(bus.launch), 32'h1);
    bus.fire_req = 2'b00;
    tick(3);

    chk("sb_queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
